// File: rtl/ptw_arbiter.sv
// ---------------------------------------------------------------------------
// ptw_arbiter
//
// Purpose:
//   Shares one page-table walker between two TLB requesters. Only one walk is
//   in flight at a time. The PTE response goes back to the requester that
//   issued the walk. When both requesters are valid, grants alternate
//   round-robin.
//
// Optional feature (macro PTW_ARB_TIMEOUT_EN):
//   A walk that waits TIMEOUT_CYCLES cycles for the PTW is completed with a
//   zero PTE. The arbiter then discards the late PTW response. Without the
//   macro the arbiter waits indefinitely and timeout_o is tied low.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   r0_* / r1_*            requester request (valid/ready/vaddr) and
//                          response (valid/ready/pte) channels
//   ptw_req_*, ptw_vaddr_o walk request towards the PTW
//   ptw_resp_*, ptw_pte_i  PTE response from the PTW
//   timeout_o              one-cycle pulse when a walk times out
// ---------------------------------------------------------------------------
module ptw_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req_valid_i,
  output logic        r0_req_ready_o,
  input  logic [31:0] r0_vaddr_i,
  output logic        r0_resp_valid_o,
  input  logic        r0_resp_ready_i,
  output logic [31:0] r0_pte_o,
  input  logic        r1_req_valid_i,
  output logic        r1_req_ready_o,
  input  logic [31:0] r1_vaddr_i,
  output logic        r1_resp_valid_o,
  input  logic        r1_resp_ready_i,
  output logic [31:0] r1_pte_o,
  output logic        ptw_req_valid_o,
  input  logic        ptw_req_ready_i,
  output logic [31:0] ptw_vaddr_o,
  input  logic        ptw_resp_valid_i,
  output logic        ptw_resp_ready_o,
  input  logic [31:0] ptw_pte_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, RESPOND} state_t;

  state_t      state, state_next;
  logic        owner, prio;
  logic [31:0] vaddr_q, pte_q;

  logic        grant;
  logic        req_fire;
  logic        resp_fire;
  logic        pte_load;
  logic [31:0] pte_next;
  logic        timeout_hit;
  logic        drain;

  // An out-of-range timeout parameter is rejected at elaboration.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("ptw_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  // Next-state and output decode. Everything defaults to idle/zero.
  always_comb begin
    state_next       = state;
    grant            = 1'b0;
    req_fire         = 1'b0;
    resp_fire        = 1'b0;
    pte_load         = 1'b0;
    pte_next         = ptw_pte_i;
    r0_req_ready_o   = 1'b0;
    r1_req_ready_o   = 1'b0;
    r0_resp_valid_o  = 1'b0;
    r1_resp_valid_o  = 1'b0;
    ptw_req_valid_o  = 1'b0;
    // A pending drain swallows the late PTW response in any state.
    ptw_resp_ready_o = drain;
    case (state)
      IDLE: begin
        // A lone valid requester wins. On a tie, prio decides.
        grant          = (r0_req_valid_i && r1_req_valid_i) ? prio : r1_req_valid_i;
        r0_req_ready_o = r0_req_valid_i && !grant;
        r1_req_ready_o = r1_req_valid_i && grant;
        req_fire       = r0_req_valid_i || r1_req_valid_i;
        if (req_fire) state_next = SEND;
      end
      SEND: begin
        // A new walk must not start until the timed-out one has been drained.
        ptw_req_valid_o = !drain;
        if (!drain && ptw_req_ready_i) state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        ptw_resp_ready_o = 1'b1;
        if (ptw_resp_valid_i) begin
          pte_load   = 1'b1;
          state_next = RESPOND;
        end else if (timeout_hit) begin
          pte_load   = 1'b1;
          pte_next   = '0;
          state_next = RESPOND;
        end
      end
      RESPOND: begin
        r0_resp_valid_o = !owner;
        r1_resp_valid_o = owner;
        resp_fire       = owner ? r1_resp_ready_i : r0_resp_ready_i;
        if (resp_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus walk context. prio flips to the other requester
  // after each completed walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      prio    <= 1'b0;
      vaddr_q <= '0;
      pte_q   <= '0;
    end else begin
      state <= state_next;
      if (req_fire) begin
        owner   <= grant;
        vaddr_q <= grant ? r1_vaddr_i : r0_vaddr_i;
      end
      if (pte_load) pte_q <= pte_next;
      if (resp_fire) prio <= ~owner;
    end
  end

`ifdef PTW_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt;
  logic        drain_q;

  // A response arriving in the same cycle always beats the timeout.
  assign timeout_hit = (state == WAIT_RESP) && !ptw_resp_valid_i && (tmo_cnt == TIMEOUT_LAST);
  assign drain       = drain_q;

  // The counter is held at zero outside WAIT_RESP, so every entry to
  // WAIT_RESP starts a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      drain_q <= 1'b0;
    end else begin
      if (state != WAIT_RESP) tmo_cnt <= '0;
      else                    tmo_cnt <= tmo_cnt + 16'd1;
      if (timeout_hit)                       drain_q <= 1'b1;
      else if (drain_q && ptw_resp_valid_i) drain_q <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign drain       = 1'b0;
`endif

  assign timeout_o   = timeout_hit;
  assign ptw_vaddr_o = vaddr_q;
  assign r0_pte_o    = r0_resp_valid_o ? pte_q : '0;
  assign r1_pte_o    = r1_resp_valid_o ? pte_q : '0;

endmodule

// File: tb/tb_ptw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ptw_arbiter
//
// Self-checking bench for ptw_arbiter. A walk-level reference model
// (busy / owner / sent / have-PTE record) predicts every output on every
// cycle. Directed sequences add hand-computed literal expectations, and a
// randomized phase drives both requesters and a variable-latency PTW.
// Build with PTW_ARB_TIMEOUT_EN to include the timeout/drain sequence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ptw_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, resp_rdy;
  logic [31:0] req_addr [2];
  wire  [1:0]  req_ready, resp_valid;
  wire  [31:0] pte_out [2];
  logic        ptw_req_ready, ptw_resp_valid;
  logic [31:0] ptw_pte;
  wire         ptw_req_valid, ptw_resp_ready, timeout;
  wire  [31:0] ptw_vaddr;

  int checks = 0;
  int errors = 0;

  // Handshakes seen at the last falling edge; the driver reacts to them.
  logic [1:0] hs_req;
  logic       hs_preq, hs_presp;
  int         n_preq, n_presp0;

  // Walk-level reference model.
  logic        m_busy, m_owner, m_sent, m_have, m_drain, m_prio;
  logic [31:0] m_addr, m_pte;
  int          m_wait;

  always #5 clk = ~clk;

  ptw_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .r0_req_valid_i   (req_valid[0]),
    .r0_req_ready_o   (req_ready[0]),
    .r0_vaddr_i       (req_addr[0]),
    .r0_resp_valid_o  (resp_valid[0]),
    .r0_resp_ready_i  (resp_rdy[0]),
    .r0_pte_o         (pte_out[0]),
    .r1_req_valid_i   (req_valid[1]),
    .r1_req_ready_o   (req_ready[1]),
    .r1_vaddr_i       (req_addr[1]),
    .r1_resp_valid_o  (resp_valid[1]),
    .r1_resp_ready_i  (resp_rdy[1]),
    .r1_pte_o         (pte_out[1]),
    .ptw_req_valid_o  (ptw_req_valid),
    .ptw_req_ready_i  (ptw_req_ready),
    .ptw_vaddr_o      (ptw_vaddr),
    .ptw_resp_valid_i (ptw_resp_valid),
    .ptw_resp_ready_o (ptw_resp_ready),
    .ptw_pte_i        (ptw_pte),
    .timeout_o        (timeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] rv, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [1:0] rr, input logic preq_rdy, input logic presp_v,
                               input logic [31:0] pte);
    req_valid      = rv;
    req_addr[0]    = a0;
    req_addr[1]    = a1;
    resp_rdy       = rr;
    ptw_req_ready  = preq_rdy;
    ptw_resp_valid = presp_v;
    ptw_pte        = pte;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One zero-wait walk for requester 'who', starting in IDLE with its valid up.
  task automatic runWalk(input int who, input logic [31:0] addr, input logic [31:0] pte, input string tag);
    #1 checkOutput({tag, "_grant"}, {30'd0, req_ready}, (who == 0) ? 32'd1 : 32'd2);
    step();
    req_valid[who] = 1'b0;
    ptw_req_ready  = 1'b1;
    #1 checkOutput({tag, "_ptw_req_valid"}, {31'd0, ptw_req_valid}, 32'd1);
    checkOutput({tag, "_ptw_vaddr"}, ptw_vaddr, addr);
    step();
    ptw_req_ready  = 1'b0;
    ptw_resp_valid = 1'b1;
    ptw_pte        = pte;
    #1 checkOutput({tag, "_ptw_resp_ready"}, {31'd0, ptw_resp_ready}, 32'd1);
    step();
    ptw_resp_valid = 1'b0;
    resp_rdy       = 2'b11;
    #1 checkOutput({tag, "_resp_valid"}, {30'd0, resp_valid}, (who == 0) ? 32'd1 : 32'd2);
    checkOutput({tag, "_pte_owner"}, pte_out[who], pte);
    checkOutput({tag, "_pte_other"}, pte_out[1 - who], 32'd0);
    step();
    resp_rdy = 2'b00;
    #1 checkOutput({tag, "_resp_done"}, {30'd0, resp_valid}, 32'd0);
  endtask

  // Per-cycle compare against the model, then advance the model by one edge.
  always @(negedge clk) begin : compare
    logic        idle, g, waiting, exp_tmo, exp_preq, drain_set;
    logic [1:0]  exp_rdy, exp_rv;
    logic [31:0] exp_p0, exp_p1;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_sent = 0; m_have = 0; m_drain = 0; m_prio = 0;
      m_addr = 0; m_pte = 0; m_wait = 0;
      hs_req = 0; hs_preq = 0; hs_presp = 0;
    end else begin
      idle    = !m_busy;
      g       = (req_valid == 2'b11) ? m_prio : req_valid[1];
      exp_rdy = 2'b00;
      if (idle && req_valid != 2'b00) exp_rdy[g] = 1'b1;
      waiting  = m_busy && m_sent && !m_have;
      exp_preq = m_busy && !m_sent && !m_drain;
      exp_tmo  = 1'b0;
`ifdef PTW_ARB_TIMEOUT_EN
      exp_tmo  = waiting && !ptw_resp_valid && (m_wait == TMO - 1);
`endif
      exp_rv = m_have ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      exp_p0 = exp_rv[0] ? m_pte : 32'd0;
      exp_p1 = exp_rv[1] ? m_pte : 32'd0;

      checkOutput("m_req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
      checkOutput("m_ptw_req_valid", {31'd0, ptw_req_valid}, {31'd0, exp_preq});
      if (exp_preq) checkOutput("m_ptw_vaddr", ptw_vaddr, m_addr);
      checkOutput("m_ptw_resp_ready", {31'd0, ptw_resp_ready}, {31'd0, waiting || m_drain});
      checkOutput("m_resp_valid", {30'd0, resp_valid}, {30'd0, exp_rv});
      checkOutput("m_pte0", pte_out[0], exp_p0);
      checkOutput("m_pte1", pte_out[1], exp_p1);
      checkOutput("m_timeout", {31'd0, timeout}, {31'd0, exp_tmo});

      hs_req   = req_valid & req_ready;
      hs_preq  = ptw_req_valid && ptw_req_ready;
      hs_presp = ptw_resp_valid && ptw_resp_ready;
      if (hs_preq) n_preq++;
      if (resp_valid[0] && resp_rdy[0]) n_presp0++;

      drain_set = 1'b0;
      if (idle) begin
        if (req_valid != 2'b00) begin
          m_busy = 1; m_owner = g; m_addr = req_addr[g]; m_sent = 0; m_have = 0;
        end
      end else if (!m_sent) begin
        if (!m_drain && ptw_req_ready) begin
          m_sent = 1; m_wait = 0;
        end
      end else if (!m_have) begin
        if (ptw_resp_valid) begin
          m_have = 1; m_pte = ptw_pte;
        end else if (exp_tmo) begin
          m_have = 1; m_pte = 0; drain_set = 1;
        end else begin
          m_wait++;
        end
      end else if (resp_rdy[m_owner]) begin
        m_busy = 0; m_have = 0; m_prio = !m_owner;
      end
      if (m_drain && ptw_resp_valid) m_drain = 0;
      if (drain_set) m_drain = 1;
    end
  end

  initial begin : main
    logic       ptw_pend;
    int         ptw_delay;

    // Reset values, observed while reset is held.
    rst = 1'b1;
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    #12;
    checkOutput("rst_req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    checkOutput("rst_ptw_req_valid", {31'd0, ptw_req_valid}, 32'd0);
    checkOutput("rst_ptw_resp_ready", {31'd0, ptw_resp_ready}, 32'd0);
    checkOutput("rst_ptw_vaddr", ptw_vaddr, 32'd0);
    checkOutput("rst_pte0", pte_out[0], 32'd0);
    checkOutput("rst_timeout", {31'd0, timeout}, 32'd0);
    resetDut();

    // Single zero-wait walk from r0.
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h12345678;
    runWalk(0, 32'h12345678, 32'hABCDE007, "single");

    // Simultaneous requests after reset: r0 first, then r0 re-requests and
    // r1 wins the tie, then r0 again.
    resetDut();
    applyStimulus(2'b11, 32'h00001000, 32'h00002000, 2'b00, 1'b0, 1'b0, 32'h0);
    runWalk(0, 32'h00001000, 32'h11110001, "tie_a");
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h00003000;
    runWalk(1, 32'h00002000, 32'h22220001, "tie_b");
    runWalk(0, 32'h00003000, 32'h33330001, "tie_c");

    // Back-pressure on both sides: values hold, one handshake each.
    resetDut();
    n_preq = 0; n_presp0 = 0;
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0BADF00D;
    step();
    req_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 checkOutput("stall_ptw_req_valid", {31'd0, ptw_req_valid}, 32'd1);
      checkOutput("stall_ptw_vaddr", ptw_vaddr, 32'h0BADF00D);
      step();
    end
    ptw_req_ready = 1'b1;
    step();
    ptw_req_ready  = 1'b0;
    ptw_resp_valid = 1'b1;
    ptw_pte        = 32'h5555AAAA;
    step();
    ptw_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("stall_resp_valid", {30'd0, resp_valid}, 32'd1);
      checkOutput("stall_pte0", pte_out[0], 32'h5555AAAA);
      step();
    end
    resp_rdy[0] = 1'b1;
    step();
    resp_rdy[0] = 1'b0;
    #1 checkOutput("stall_ptw_hs_count", n_preq, 32'd1);
    checkOutput("stall_resp_hs_count", n_presp0, 32'd1);

    // Reset while waiting for the PTW, then a normal walk.
    resetDut();
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h00C0FFEE;
    step();
    req_valid[0]  = 1'b0;
    ptw_req_ready = 1'b1;
    step();
    ptw_req_ready = 1'b0;
    #1 checkOutput("midrst_waiting", {31'd0, ptw_resp_ready}, 32'd1);
    rst = 1'b1;
    #1 checkOutput("midrst_ptw_resp_ready", {31'd0, ptw_resp_ready}, 32'd0);
    checkOutput("midrst_ptw_vaddr", ptw_vaddr, 32'd0);
    checkOutput("midrst_ptw_req_valid", {31'd0, ptw_req_valid}, 32'd0);
    checkOutput("midrst_resp_valid", {30'd0, resp_valid}, 32'd0);
    step();
    rst = 1'b0;
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h7654_3210;
    runWalk(1, 32'h76543210, 32'h0F0F0F01, "after_rst");

`ifdef PTW_ARB_TIMEOUT_EN
    // Silent PTW: timeout after TMO cycles in WAIT_RESP, zero PTE, late
    // response drained, next walk normal.
    resetDut();
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h00ABC000;
    step();
    req_valid[0]  = 1'b0;
    ptw_req_ready = 1'b1;
    step();
    ptw_req_ready = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      #1 checkOutput("tmo_quiet", {31'd0, timeout}, 32'd0);
      step();
    end
    #1 checkOutput("tmo_pulse", {31'd0, timeout}, 32'd1);
    step();
    #1 checkOutput("tmo_resp_valid", {30'd0, resp_valid}, 32'd1);
    checkOutput("tmo_pte0", pte_out[0], 32'd0);
    checkOutput("tmo_pulse_end", {31'd0, timeout}, 32'd0);
    checkOutput("tmo_drain_ready", {31'd0, ptw_resp_ready}, 32'd1);
    resp_rdy[0] = 1'b1;
    step();
    resp_rdy[0]    = 1'b0;
    ptw_resp_valid = 1'b1;
    ptw_pte        = 32'hDEAD0001;
    #1 checkOutput("drain_accept", {31'd0, ptw_resp_ready}, 32'd1);
    step();
    ptw_resp_valid = 1'b0;
    #1 checkOutput("drain_done", {31'd0, ptw_resp_ready}, 32'd0);
    checkOutput("drain_no_resp", {30'd0, resp_valid}, 32'd0);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h00ABD000;
    runWalk(0, 32'h00ABD000, 32'h00ABD00F, "post_tmo");
`endif

    // Randomized traffic: both requesters and a PTW with 0..3 cycles latency.
    resetDut();
    ptw_pend  = 1'b0;
    ptw_delay = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (hs_req[i])                                      req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(15) == 0) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_valid[i] = 1'b1;
          req_addr[i]  = $urandom;
        end
        resp_rdy[i] = ($urandom_range(2) != 0);
      end
      if (hs_presp) ptw_resp_valid = 1'b0;
      if (hs_preq) begin
        ptw_pend  = 1'b1;
        ptw_delay = $urandom_range(3);
      end
      if (ptw_pend && !ptw_resp_valid) begin
        if (ptw_delay == 0) begin
          ptw_resp_valid = 1'b1;
          ptw_pte        = $urandom;
          ptw_pend       = 1'b0;
        end else begin
          ptw_delay--;
        end
      end
      ptw_req_ready = ($urandom_range(1) != 0);
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
